multicycle_control_unit: RTL

- Multi-cycle successor to the single-cycle opcode decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the same datapath mux and write controls, but only in the state where each control is valid.
- Adds handshakes to instruction and data memory, and an instruction-register (IR) write strobe.
- Sits between the IR/PC and the datapath muxes, register file and data memory.

---
 rtl/multicycle_control_unit_pkg.sv | 63 ++++++
 rtl/mcu_output_decode.sv | 82 ++++++++
 rtl/multicycle_control_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, state codes, ALUop
// constants and the packed control vector. MCU_ILLEGAL_TRAP_EN adds the HALT state.
package multicycle_control_unit_pkg;

   localparam int OPC_W = 5;
   localparam int ALU_W = 4;

   localparam logic [ALU_W-1:0] ALUOP_PASS = 4'b1111;
   localparam logic [ALU_W-1:0] ALUOP_ADDR = 4'b0000;

   localparam logic [OPC_W-1:0] OP_LOAD  = 5'b00000;
   localparam logic [OPC_W-1:0] OP_I     = 5'b00001;
   localparam logic [OPC_W-1:0] OP_AR    = 5'b00010;
   localparam logic [OPC_W-1:0] OP_J     = 5'b00011;
   localparam logic [OPC_W-1:0] OP_M     = 5'b00100;
   localparam logic [OPC_W-1:0] OP_T     = 5'b01011;
   localparam logic [OPC_W-1:0] OP_STORE = 5'b01100;

`ifdef MCU_ILLEGAL_TRAP_EN
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_e;
`else
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_e;
`endif

   typedef struct packed {
      logic [ALU_W-1:0] aluop;
      logic             reg_write;
      logic             mux_write_reg;
      logic             mux_write_data;
      logic             reg2_alub;
      logic             sub_alub_l;
      logic             dm_vs_alu;
      logic             l_mux;
      logic             offset;
      logic             pc_src;
      logic             pc_write;
      logic             ir_write;
      logic             read_dm;
      logic             write_dm;
      logic             imem_req;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   function automatic logic op_is_legal(input logic [OPC_W-1:0] op);
      return (op == OP_LOAD) || (op == OP_I) || (op == OP_AR) || (op == OP_J) ||
             (op == OP_M) || (op == OP_T) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/mcu_output_decode.sv
// Combinational map from FSM state and latched opcode to the datapath control vector.
// Only imem_ready (FETCH) and branchIdea (EXEC of M) reach the outputs directly.
module mcu_output_decode
   import multicycle_control_unit_pkg::*;
(
   input  logic [2:0]        state_i,
   input  logic [OPC_W-1:0]  opcode_i,
   input  logic              branch_i,
   input  logic              imem_ready_i,
   output logic [CTRL_W-1:0] ctrl_o
);

   ctrl_t c;

   always_comb begin
      c = '0;
      case (state_i)
         ST_FETCH: begin
            c.imem_req = 1'b1;
            if (imem_ready_i) begin
               c.ir_write = 1'b1;
               c.pc_write = 1'b1;
            end
         end
         ST_EXEC: begin
            case (opcode_i)
               OP_AR, OP_T: begin
                  c.aluop = ALUOP_PASS;
               end
               OP_I: begin
                  c.aluop     = ALUOP_PASS;
                  c.reg2_alub = 1'b1;
               end
               OP_J: begin
                  c.pc_src   = 1'b1;
                  c.pc_write = 1'b1;
               end
               OP_M: begin
                  c.offset   = 1'b1;
                  c.pc_src   = branch_i;
                  c.pc_write = branch_i;
               end
               OP_LOAD, OP_STORE: begin
                  c.aluop      = ALUOP_ADDR;
                  c.reg2_alub  = 1'b1;
                  c.sub_alub_l = 1'b1;
               end
               default: ;
            endcase
         end
         // Address operands stay stable for the whole memory access, wait states included.
         ST_MEM: begin
            c.aluop      = ALUOP_ADDR;
            c.reg2_alub  = 1'b1;
            c.sub_alub_l = 1'b1;
            c.read_dm    = (opcode_i == OP_LOAD);
            c.write_dm   = (opcode_i == OP_STORE);
         end
         ST_WB: begin
            c.reg_write = 1'b1;
            case (opcode_i)
               OP_T: begin
                  c.mux_write_reg  = 1'b1;
                  c.mux_write_data = 1'b1;
               end
               OP_I: begin
                  c.mux_write_reg = 1'b1;
               end
               OP_LOAD: begin
                  c.dm_vs_alu = 1'b1;
                  c.l_mux     = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign ctrl_o = c;

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes.
// Define MCU_ILLEGAL_TRAP_EN to trap illegal opcodes into a sticky HALT state.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int OPCODE_W = 5,
   parameter int ALUOP_W  = 4
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                branchIdea,
   input  logic                imem_ready,
   input  logic                dmem_ready,
   output logic [ALUOP_W-1:0]  ALUop,
   output logic                regWrite,
   output logic                muxWriteReg,
   output logic                muxWriteData,
   output logic                C_reg2_aluB_mux,
   output logic                C_sub_mAluInputB_L,
   output logic                C_mDataMemVsAluOutput,
   output logic                C_L_mux,
   output logic                C_offset,
   output logic                pcSrc,
   output logic                pc_write,
   output logic                ir_write,
   output logic                C_read_dm,
   output logic                C_write_dm,
   output logic                imem_req,
   output logic [2:0]          state,
   output logic                illegal_op
);

   // Reset asserts asynchronously but releases two clock edges after RST_N rises.
   logic [1:0] rst_sync_q;
   logic       rst_n_int;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n_int = rst_sync_q[1];

   state_e           state_q, state_d;
   logic [OPC_W-1:0] opcode_q, opcode_d;
`ifdef MCU_ILLEGAL_TRAP_EN
   logic             illegal_q, illegal_d;
`endif

   always_ff @(posedge CLK or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q   <= ST_FETCH;
         opcode_q  <= '0;
`ifdef MCU_ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
`ifdef MCU_ILLEGAL_TRAP_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      opcode_d  = opcode_q;
`ifdef MCU_ILLEGAL_TRAP_EN
      illegal_d = illegal_q;
`endif
      case (state_q)
         ST_FETCH: begin
            if (imem_ready) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            opcode_d = OPC_W'(opcode);
            state_d  = ST_EXEC;
         end
         ST_EXEC: begin
            if (!op_is_legal(opcode_q)) begin
`ifdef MCU_ILLEGAL_TRAP_EN
               state_d   = ST_HALT;
               illegal_d = 1'b1;
`else
               state_d   = ST_FETCH;
`endif
            end else if ((opcode_q == OP_LOAD) || (opcode_q == OP_STORE)) begin
               state_d = ST_MEM;
            end else if ((opcode_q == OP_J) || (opcode_q == OP_M)) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            if (dmem_ready) state_d = (opcode_q == OP_LOAD) ? ST_WB : ST_FETCH;
         end
         ST_WB: begin
            state_d = ST_FETCH;
         end
`ifdef MCU_ILLEGAL_TRAP_EN
         ST_HALT: begin
            state_d = ST_HALT;
         end
`endif
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   logic [CTRL_W-1:0] ctrl_vec;
   ctrl_t             ctrl;

   mcu_output_decode u_decode (
      .state_i      (state_q),
      .opcode_i     (opcode_q),
      .branch_i     (branchIdea),
      .imem_ready_i (imem_ready),
      .ctrl_o       (ctrl_vec)
   );

   // Gating keeps every control low while reset is asserted or still synchronising.
   assign ctrl = rst_n_int ? ctrl_t'(ctrl_vec) : '0;

   assign ALUop                 = ALUOP_W'(ctrl.aluop);
   assign regWrite              = ctrl.reg_write;
   assign muxWriteReg           = ctrl.mux_write_reg;
   assign muxWriteData          = ctrl.mux_write_data;
   assign C_reg2_aluB_mux       = ctrl.reg2_alub;
   assign C_sub_mAluInputB_L    = ctrl.sub_alub_l;
   assign C_mDataMemVsAluOutput = ctrl.dm_vs_alu;
   assign C_L_mux               = ctrl.l_mux;
   assign C_offset              = ctrl.offset;
   assign pcSrc                 = ctrl.pc_src;
   assign pc_write              = ctrl.pc_write;
   assign ir_write              = ctrl.ir_write;
   assign C_read_dm             = ctrl.read_dm;
   assign C_write_dm            = ctrl.write_dm;
   assign imem_req              = ctrl.imem_req;
   assign state                 = state_q;

`ifdef MCU_ILLEGAL_TRAP_EN
   assign illegal_op = illegal_q;
`else
   assign illegal_op = 1'b0;
`endif

endmodule
